// File: rtl/threshold_calibrator.sv
// Acquisition-window min/max tracker that derives hysteresis thresholds
// centred on the signal midpoint for the position tracker.
module threshold_calibrator #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int WINDOW_WIDTH     = 24,
  parameter int HYST_SHIFT       = 2
) (
  input  logic                        SYS_aclk,
  input  logic                        SYS_areset,
  input  logic                        CTRL_start,
  input  logic                        CTRL_abort,
  input  logic [WINDOW_WIDTH-1:0]     CTRL_window,
  input  logic [AXIS_TDATA_WIDTH-1:0] CTRL_min_span,
  input  logic                        S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic                        S_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] FC_lower_treshold,
  output logic [AXIS_TDATA_WIDTH-1:0] FC_upper_treshold,
  output logic                        FC_valid,
  output logic                        STAT_busy,
  output logic                        STAT_error
);

  localparam int W = AXIS_TDATA_WIDTH;

  // state   | meaning
  // IDLE    | waiting for CTRL_start
  // ACQUIRE | tracking min/max over the sample window
  // SPAN    | computing midpoint, span and hysteresis
  // APPLY   | span check, threshold update on success
  typedef enum logic [1:0] {IDLE, ACQUIRE, SPAN, APPLY} state_t;

  state_t                  state_q, state_d;
  logic [WINDOW_WIDTH-1:0] count_q, count_d;
  logic [W-1:0]            min_q, min_d;
  logic [W-1:0]            max_q, max_d;
  logic                    first_q, first_d;
  logic [W-1:0]            min_span_q, min_span_d;
  logic [W-1:0]            mid_q, mid_d;
  logic [W:0]              span_q, span_d;
  logic [W:0]              hyst_q, hyst_d;
  logic [W-1:0]            lower_q, lower_d;
  logic [W-1:0]            upper_q, upper_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    error_q, error_d;

  logic signed [W:0]       max_ext, min_ext, sum, mid_ext;

  always_comb begin
    max_ext = {max_q[W-1], max_q};
    min_ext = {min_q[W-1], min_q};
    sum     = max_ext + min_ext;
    mid_ext = {mid_q[W-1], mid_q};
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    min_d      = min_q;
    max_d      = max_q;
    first_d    = first_q;
    min_span_d = min_span_q;
    mid_d      = mid_q;
    span_d     = span_q;
    hyst_d     = hyst_q;
    lower_d    = lower_q;
    upper_d    = upper_q;
    valid_d    = valid_q;
    error_d    = error_q;

    case (state_q)
      IDLE: begin
        if (CTRL_start && !CTRL_abort) begin
          count_d    = (CTRL_window == '0) ? WINDOW_WIDTH'(1) : CTRL_window;
          min_span_d = CTRL_min_span;
          valid_d    = 1'b0;
          error_d    = 1'b0;
          first_d    = 1'b1;
          state_d    = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (CTRL_abort) begin
          state_d = IDLE;
        end else if (S_AXIS_tvalid) begin
          first_d = 1'b0;
          if (first_q) begin
            min_d = S_AXIS_tdata;
            max_d = S_AXIS_tdata;
          end else begin
            if ($signed(S_AXIS_tdata) < $signed(min_q)) min_d = S_AXIS_tdata;
            if ($signed(S_AXIS_tdata) > $signed(max_q)) max_d = S_AXIS_tdata;
          end
          count_d = count_q - 1'b1;
          if (count_q == WINDOW_WIDTH'(1)) state_d = SPAN;
        end
      end
      SPAN: begin
        if (CTRL_abort) begin
          state_d = IDLE;
        end else begin
          mid_d   = W'(sum >>> 1);
          span_d  = max_ext - min_ext;
          hyst_d  = (max_ext - min_ext) >> HYST_SHIFT;
          state_d = APPLY;
        end
      end
      APPLY: begin
        state_d = IDLE;
        if (!CTRL_abort) begin
          if (span_q < {1'b0, min_span_q}) begin
            error_d = 1'b1;
          end else begin
            // Results stay within [min, max], so truncation to W bits is exact.
            lower_d = W'(mid_ext - hyst_q);
            upper_d = W'(mid_ext + hyst_q);
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge SYS_aclk) begin
    if (SYS_areset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      min_q      <= '0;
      max_q      <= '0;
      first_q    <= 1'b0;
      min_span_q <= '0;
      mid_q      <= '0;
      span_q     <= '0;
      hyst_q     <= '0;
      lower_q    <= '0;
      upper_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      min_q      <= min_d;
      max_q      <= max_d;
      first_q    <= first_d;
      min_span_q <= min_span_d;
      mid_q      <= mid_d;
      span_q     <= span_d;
      hyst_q     <= hyst_d;
      lower_q    <= lower_d;
      upper_q    <= upper_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  assign S_AXIS_tready     = 1'b1;
  assign FC_lower_treshold = lower_q;
  assign FC_upper_treshold = upper_q;
  assign FC_valid          = valid_q;
  assign STAT_busy         = busy_q;
  assign STAT_error        = error_q;

endmodule

// File: tb/tb_threshold_calibrator.sv
// Scoreboard bench for threshold_calibrator: each run queues its expected
// result, and a monitor checks it when STAT_busy falls.
module tb_threshold_calibrator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [23:0] window = '0;
  logic [31:0] min_span = '0;
  logic        tvalid = 1'b0;
  logic [31:0] tdata = '0;
  logic        tready;
  logic [31:0] lower, upper;
  logic        fvalid, busy, err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        v;
    logic        e;
    int          nbusy;
  } exp_t;
  exp_t sb[$];

  threshold_calibrator dut (
    .SYS_aclk(clk), .SYS_areset(rst),
    .CTRL_start(start), .CTRL_abort(abort),
    .CTRL_window(window), .CTRL_min_span(min_span),
    .S_AXIS_tvalid(tvalid), .S_AXIS_tdata(tdata), .S_AXIS_tready(tready),
    .FC_lower_treshold(lower), .FC_upper_treshold(upper),
    .FC_valid(fvalid), .STAT_busy(busy), .STAT_error(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: a falling STAT_busy marks the end of a run.
  int  bcnt = 0;
  int  run_id = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t x;
    if (busy === 1'b1) begin
      bcnt++;
    end else if (prev_busy === 1'b1) begin
      run_id++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL run%0d unexpected_end: got busy fall, expected none", run_id);
      end else begin
        x = sb.pop_front();
        check($sformatf("run%0d lower", run_id), lower, x.lo);
        check($sformatf("run%0d upper", run_id), upper, x.hi);
        check($sformatf("run%0d valid", run_id), {31'd0, fvalid}, {31'd0, x.v});
        check($sformatf("run%0d error", run_id), {31'd0, err}, {31'd0, x.e});
        check($sformatf("run%0d busy_cycles", run_id), bcnt, x.nbusy);
      end
      bcnt = 0;
    end
    prev_busy = busy;
  end

  task automatic expect_res(input logic [31:0] lo, input logic [31:0] hi,
                            input logic v, input logic e, input int nb);
    exp_t x;
    x.lo = lo; x.hi = hi; x.v = v; x.e = e; x.nbusy = nb;
    sb.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [23:0] w, input logic [31:0] ms);
    start = 1'b1; window = w; min_span = ms;
    cyc();
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] d, input int gap, input logic also_start);
    tvalid = 1'b1; tdata = d; start = also_start;
    cyc();
    tvalid = 1'b0; start = 1'b0;
    repeat (gap) cyc();
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy === 1'b1 && k < 64) begin
      cyc();
      k++;
    end
    if (busy !== 1'b0) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: got busy=%b, expected 0", name, busy);
    end
    cyc();
    cyc();
  endtask

  task automatic nominal(input int gap, input logic start_mid, input int nb);
    expect_res(32'hFFFF_FF9C, 32'd300, 1'b1, 1'b0, nb);
    do_start(24'd4, 32'd0);
    feed(32'd100, gap, 1'b0);
    feed(32'hFFFF_FED4, gap, start_mid);
    feed(32'd500, gap, 1'b0);
    feed(32'd20, 0, 1'b0);
    wait_idle("nominal");
  endtask

  initial begin
    repeat (2) cyc();
    check("reset lower", lower, 32'd0);
    check("reset upper", upper, 32'd0);
    check("reset valid_busy_error", {29'd0, fvalid, busy, err}, 32'd0);
    check("tready", {31'd0, tready}, 32'd1);
    rst = 1'b0;
    cyc();

    // Nominal contiguous, then gapped by 3 idle cycles.
    nominal(0, 1'b0, 6);
    nominal(3, 1'b0, 15);

    // Extremes: mid=-1, span=0xFFFFFFFF.
    expect_res(32'hC000_0000, 32'h3FFF_FFFE, 1'b1, 1'b0, 4);
    do_start(24'd2, 32'd0);
    feed(32'h7FFF_FFFF, 0, 1'b0);
    feed(32'h8000_0000, 0, 1'b0);
    wait_idle("extremes");

    // Span failure after a good run keeps the old thresholds.
    nominal(0, 1'b0, 6);
    expect_res(32'hFFFF_FF9C, 32'd300, 1'b0, 1'b1, 5);
    do_start(24'd3, 32'd16);
    feed(32'd10, 0, 1'b0);
    feed(32'd12, 0, 1'b0);
    feed(32'd11, 0, 1'b0);
    wait_idle("span_fail");

    // window=0 behaves as a single sample; also clears the sticky error.
    expect_res(32'd42, 32'd42, 1'b1, 1'b0, 3);
    do_start(24'd0, 32'd0);
    feed(32'd42, 0, 1'b0);
    wait_idle("window0");

    // CTRL_start during ACQUIRE is ignored.
    nominal(0, 1'b1, 6);

    // Abort after 2 of 4 samples.
    expect_res(32'hFFFF_FF9C, 32'd300, 1'b0, 1'b0, 3);
    do_start(24'd4, 32'd0);
    feed(32'd1, 0, 1'b0);
    feed(32'd2, 0, 1'b0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    wait_idle("abort_acq");

    // Reset mid-ACQUIRE returns everything to reset values.
    expect_res(32'd0, 32'd0, 1'b0, 1'b0, 3);
    do_start(24'd4, 32'd0);
    feed(32'd7, 0, 1'b0);
    feed(32'd9, 0, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wait_idle("reset_mid");
    nominal(0, 1'b0, 6);

    // Abort coincident with APPLY wins over the update.
    expect_res(32'hFFFF_FF9C, 32'd300, 1'b0, 1'b0, 3);
    do_start(24'd1, 32'd0);
    feed(32'd5, 0, 1'b0);
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    wait_idle("abort_apply");

    begin
      int k = 0;
      while (sb.size() != 0 && k < 20) begin
        cyc();
        k++;
      end
      if (sb.size() != 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
